// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared constants and helpers for the clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  // Smallest legal half-period, in clk_in cycles.
  localparam int DIV_MIN = 1;

  // A DIV of 1 still needs a 1-bit counter, even though $clog2(1) is 0.
  function automatic int cnt_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_divider_if.sv
// ============================================================================
// Module   : clk_divider_if
// Purpose  : Output bundle of the clock divider.
//            tick_out is present only when CLK_DIV_TICK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_divider_if;

  logic clk_out;
`ifdef CLK_DIV_TICK_EN
  logic tick_out;
`endif

`ifdef CLK_DIV_TICK_EN
  modport master (output clk_out, output tick_out);
  modport slave  (input  clk_out, input  tick_out);
`else
  modport master (output clk_out);
  modport slave  (input  clk_out);
`endif

endinterface : clk_divider_if

`default_nettype wire

// File: rtl/clk_divider.sv
// ============================================================================
// Module   : clk_divider
// Purpose  : Divides clk_in by 2*DIV into a 50% duty registered clock.
//            Optional macro CLK_DIV_TICK_EN adds a one-cycle tick_out pulse
//            aligned with each rising edge of clk_out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_divider
  import clk_div_pkg::*;
#(
  parameter int DIV = 5
) (
  input  wire logic           clk_in,
  input  wire logic           reset,
  clk_divider_if.master       bus
);

  // Width is derived from DIV so it cannot be overridden.
  localparam int               CNT_W  = cnt_width(DIV);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  generate
    if (DIV < DIV_MIN) begin : g_div_check
      $error("clk_divider: DIV must be >= %0d, got %0d", DIV_MIN, DIV);
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             w_wrap;

  assign w_wrap = (r_cnt == c_last);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_clk_out <= ~r_clk_out;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.clk_out = r_clk_out;

`ifdef CLK_DIV_TICK_EN
  logic r_tick;

  // Registered alongside the 0->1 toggle so it marks the first high cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap & ~r_clk_out;
    end
  end

  assign bus.tick_out = r_tick;
`endif

endmodule : clk_divider

`default_nettype wire

// File: tb/tb_clk_divider.sv
// ============================================================================
// Module   : tb_clk_divider
// Purpose  : Directed self-checking bench for clk_divider at DIV = 5, 1, 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_divider;

  logic clk = 1'b0;
  logic rst5;
  logic rst_s;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  clk_divider_if if5 ();
  clk_divider_if if1 ();
  clk_divider_if if2 ();

  clk_divider #(.DIV(5)) u_dut5 (.clk_in(clk), .reset(rst5),  .bus(if5));
  clk_divider #(.DIV(1)) u_dut1 (.clk_in(clk), .reset(rst_s), .bus(if1));
  clk_divider #(.DIV(2)) u_dut2 (.clk_in(clk), .reset(rst_s), .bus(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (k=%0d): observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  // Expected clk_out after the k-th edge since reset release.
  function automatic int exp_clk(input int k, input int div);
    return (k / div) % 2;
  endfunction

  function automatic int exp_tick(input int k, input int div);
    return ((k % (2 * div)) == div) ? 1 : 0;
  endfunction

  task automatic check_all(input int k, input bit in_reset);
    check("clk5", k, int'(if5.clk_out), in_reset ? 0 : exp_clk(k, 5));
    check("clk1", k, int'(if1.clk_out), in_reset ? 0 : exp_clk(k, 1));
    check("clk2", k, int'(if2.clk_out), in_reset ? 0 : exp_clk(k, 2));
`ifdef CLK_DIV_TICK_EN
    check("tick5", k, int'(if5.tick_out), in_reset ? 0 : exp_tick(k, 5));
    check("tick1", k, int'(if1.tick_out), in_reset ? 0 : exp_tick(k, 1));
    check("tick2", k, int'(if2.tick_out), in_reset ? 0 : exp_tick(k, 2));
`endif
  endtask

  initial begin
    int rises5 = 0;
    int high5  = 0;
    int high2  = 0;
    int prev5  = 0;

    rst5  = 1'b1;
    rst_s = 1'b1;
    repeat (3) step();
    check_all(0, 1'b1);
    check("cnt5_rst", 0, int'(u_dut5.r_cnt), 0);

    rst5  = 1'b0;
    rst_s = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      check_all(k, 1'b0);
      if (prev5 == 0 && if5.clk_out == 1'b1) rises5++;
      if (if5.clk_out == 1'b1) high5++;
      if (if2.clk_out == 1'b1) high2++;
      prev5 = int'(if5.clk_out);
    end
    check("rises5", 100, rises5, 10);
    check("high5", 100, high5, 50);
    check("high2", 100, high2, 50);

    // Advance DIV=5 to the phase clk_out=1, cnt=2 (edge 107).
    for (int k = 101; k <= 107; k++) begin
      step();
      check_all(k, 1'b0);
    end
    check("clk5_pre", 107, int'(if5.clk_out), 1);
    check("cnt5_pre", 107, int'(u_dut5.r_cnt), 2);

    rst5 = 1'b1;
    step();
    check("clk5_midrst", 0, int'(if5.clk_out), 0);
    check("cnt5_midrst", 0, int'(u_dut5.r_cnt), 0);
`ifdef CLK_DIV_TICK_EN
    check("tick5_midrst", 0, int'(if5.tick_out), 0);
`endif

    rst5 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("clk5_after", k, int'(if5.clk_out), exp_clk(k, 5));
`ifdef CLK_DIV_TICK_EN
      check("tick5_after", k, int'(if5.tick_out), exp_tick(k, 5));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clk_divider

`default_nettype wire
